// File: rtl/top_alu_pkg.sv
// Shared opcode definitions for the top_alu slice.
package top_alu_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   function automatic logic is_sub_op(input logic [2:0] op);
      return (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// 1-bit full adder/subtractor; cb is carry when sub=0 and borrow when sub=1.
module alu_bit_slice (
   input  logic a,
   input  logic b,
   input  logic cb_in,
   input  logic sub,
   output logic sum,
   output logic cb_out
);

   logic a_eff;

   // Borrow of a-b-cb equals the carry expression evaluated with a inverted.
   assign a_eff  = a ^ sub;
   assign sum    = a ^ b ^ cb_in;
   assign cb_out = (a_eff & b) | ((a_eff ^ b) & cb_in);

endmodule

// File: rtl/top_alu.sv
// Registered WIDTH-bit ALU slice with ripple carry/borrow chaining.
// Optional macro TOP_ALU_VALID_EN adds in_valid/out_valid with gated loading.
module top_alu
   import top_alu_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef TOP_ALU_VALID_EN
   input  logic             in_valid,
   output logic             out_valid,
`endif
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic             CB_in,
   input  logic [2:0]       code_op,
   output logic [WIDTH-1:0] Result,
   output logic             CB_out
);

   logic             is_sub;
   logic [WIDTH:0]   chain;
   logic [WIDTH-1:0] arith_res;
   logic [WIDTH-1:0] shl_res;
   logic [WIDTH-1:0] shr_res;
   logic             shl_out;
   logic             shr_out;
   logic [WIDTH-1:0] nxt_result;
   logic             nxt_cb;

   assign is_sub   = is_sub_op(code_op);
   assign chain[0] = CB_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      alu_bit_slice u_slice (
         .a      (In1[i]),
         .b      (In2[i]),
         .cb_in  (chain[i]),
         .sub    (is_sub),
         .sum    (arith_res[i]),
         .cb_out (chain[i+1])
      );
   end

   // A single-bit slice has no interior bits, so both shifts collapse to pass-through.
   if (WIDTH == 1) begin : g_shift_narrow
      assign shl_res = CB_in;
      assign shr_res = CB_in;
   end else begin : g_shift_wide
      assign shl_res = {In1[WIDTH-2:0], CB_in};
      assign shr_res = {CB_in, In1[WIDTH-1:1]};
   end

   assign shl_out = In1[WIDTH-1];
   assign shr_out = In1[0];

   always_comb begin
      nxt_result = '0;
      nxt_cb     = 1'b0;
      case (code_op)
         OP_AND: nxt_result = In1 & In2;
         OP_OR:  nxt_result = In1 | In2;
         OP_XOR: nxt_result = In1 ^ In2;
         OP_NOT: nxt_result = ~In1;
         OP_ADD, OP_SUB: begin
            nxt_result = arith_res;
            nxt_cb     = chain[WIDTH];
         end
         OP_SHL: begin
            nxt_result = shl_res;
            nxt_cb     = shl_out;
         end
         OP_SHR: begin
            nxt_result = shr_res;
            nxt_cb     = shr_out;
         end
         default: begin
            nxt_result = '0;
            nxt_cb     = 1'b0;
         end
      endcase
   end

`ifdef TOP_ALU_VALID_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Result    <= '0;
         CB_out    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Result <= nxt_result;
            CB_out <= nxt_cb;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Result <= '0;
         CB_out <= 1'b0;
      end else begin
         Result <= nxt_result;
         CB_out <= nxt_cb;
      end
   end
`endif

endmodule

// File: tb/tb_top_alu.sv
// Self-checking bench: a 1-bit and an 8-bit top_alu checked against an arithmetic model.
module tb_top_alu;
   import top_alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a1, b1, c1;
   logic [2:0] op1;
   logic       r1, cb1;
   logic [7:0] a8, b8;
   logic       c8;
   logic [2:0] op8;
   logic [7:0] r8;
   logic       cb8;
   logic       v_in;
`ifdef TOP_ALU_VALID_EN
   logic       ov1, ov8;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   // Expected registered state ({cb,result}) and the pending values for the next edge.
   logic [8:0] exp1, exp8, pend1, pend8;
   logic       exp_ov;

   always #5 clk = ~clk;

   top_alu #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
`ifdef TOP_ALU_VALID_EN
      .in_valid(v_in), .out_valid(ov1),
`endif
      .In1(a1), .In2(b1), .CB_in(c1), .code_op(op1), .Result(r1), .CB_out(cb1)
   );

   top_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
`ifdef TOP_ALU_VALID_EN
      .in_valid(v_in), .out_valid(ov8),
`endif
      .In1(a8), .In2(b8), .CB_in(c8), .code_op(op8), .Result(r8), .CB_out(cb8)
   );

   function automatic logic [8:0] model(input int w, input logic [2:0] op,
                                        input int a, input int b, input int c);
      int mask;
      int r;
      int cb;
      mask = (1 << w) - 1;
      r    = 0;
      cb   = 0;
      case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOT: r = ~a & mask;
         OP_ADD: begin r = a + b + c; cb = r >> w; r = r & mask; end
         OP_SUB: begin cb = (a < b + c) ? 1 : 0; r = (a - b - c) & mask; end
         OP_SHL: begin r = ((a << 1) | c) & mask; cb = (a >> (w - 1)) & 1; end
         OP_SHR: begin r = (c << (w - 1)) | (a >> 1); cb = a & 1; end
         default: r = 0;
      endcase
      return 9'((cb << w) | r);
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] o1, input logic x1, input logic y1, input logic z1,
                        input logic [2:0] o8, input logic [7:0] x8, input logic [7:0] y8,
                        input logic z8);
      op1 = o1; a1 = x1; b1 = y1; c1 = z1;
      op8 = o8; a8 = x8; b8 = y8; c8 = z8;
      pend1 = model(1, o1, int'(x1), int'(y1), int'(z1));
      pend8 = model(8, o8, int'(x8), int'(y8), int'(z8));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst_n) begin
         exp1 = '0; exp8 = '0; exp_ov = 1'b0;
      end else begin
         exp_ov = v_in;
         if (v_in) begin
            exp1 = pend1;
            exp8 = pend8;
         end
      end
      #1;
      check({tag, "_w1"}, {7'b0, cb1, r1}, exp1);
      check({tag, "_w8"}, {cb8, r8}, exp8);
`ifdef TOP_ALU_VALID_EN
      check({tag, "_ov1"}, {8'b0, ov1}, {8'b0, exp_ov});
      check({tag, "_ov8"}, {8'b0, ov8}, {8'b0, exp_ov});
`endif
   endtask

   initial begin
      v_in  = 1'b1;
      exp1  = '0; exp8 = '0; exp_ov = 1'b0;

      // Reset holds outputs at zero despite a live ADD on the inputs.
      rst_n = 1'b0;
      drive(OP_ADD, 1'b1, 1'b1, 1'b1, OP_ADD, 8'h01, 8'h01, 1'b1);
      tick("reset");
      tick("reset_hold");
      rst_n = 1'b1;
      tick("reset_release");

      // Exhaustive sweep of the 1-bit slice; 8-bit slice gets random traffic alongside.
      for (int op = 0; op < 8; op++)
         for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
               for (int c = 0; c < 2; c++) begin
                  drive(3'(op), 1'(a), 1'(b), 1'(c),
                        3'($urandom_range(7)), 8'($urandom), 8'($urandom), 1'($urandom));
                  tick("sweep");
               end

      // Directed 8-bit boundary cases.
      drive(OP_ADD, 1'b1, 1'b1, 1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0);  tick("add_wrap");
      drive(OP_SUB, 1'b0, 1'b1, 1'b0, OP_SUB, 8'h10, 8'h01, 1'b1);  tick("sub_borrow_in");
      drive(OP_SUB, 1'b1, 1'b0, 1'b1, OP_SHL, 8'h81, 8'h00, 1'b0);  tick("shl");
      drive(OP_XOR, 1'b1, 1'b1, 1'b1, OP_SHR, 8'h81, 8'h00, 1'b1);  tick("shr");
      drive(OP_ADD, 1'b1, 1'b1, 1'b1, OP_ADD, 8'hFF, 8'hFF, 1'b1);  tick("add_all_ones");
      drive(OP_SUB, 1'b0, 1'b0, 1'b1, OP_SUB, 8'h00, 8'h00, 1'b1);  tick("sub_zero");
      drive(OP_SUB, 1'b1, 1'b1, 1'b0, OP_SUB, 8'h5A, 8'h5A, 1'b0);  tick("sub_equal");

      // Back-to-back opcode changes, one result per cycle.
      drive(OP_AND, 1'b1, 1'b0, 1'b0, OP_AND, 8'hF0, 8'h3C, 1'b1);  tick("b2b_and");
      drive(OP_OR,  1'b0, 1'b1, 1'b0, OP_OR,  8'hF0, 8'h0C, 1'b1);  tick("b2b_or");
      drive(OP_NOT, 1'b0, 1'b1, 1'b1, OP_NOT, 8'hA5, 8'hFF, 1'b1);  tick("b2b_not");
      drive(OP_ADD, 1'b1, 1'b0, 1'b1, OP_ADD, 8'h7F, 8'h80, 1'b1);  tick("b2b_add");

      // Mid-stream reset discards the in-flight op.
      drive(OP_NOT, 1'b0, 1'b0, 1'b0, OP_NOT, 8'h00, 8'h00, 1'b0);  tick("pre_reset");
      rst_n = 1'b0;
      drive(OP_OR, 1'b1, 1'b1, 1'b1, OP_OR, 8'hFF, 8'hFF, 1'b1);
      tick("mid_reset");
      rst_n = 1'b1;
      tick("post_reset");

      // Random traffic on both slices.
      for (int i = 0; i < 300; i++) begin
         drive(3'($urandom_range(7)), 1'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom_range(7)), 8'($urandom), 8'($urandom), 1'($urandom));
         tick("random");
      end

`ifdef TOP_ALU_VALID_EN
      v_in = 1'b0;
      drive(OP_XOR, 1'b1, 1'b0, 1'b0, OP_XOR, 8'h33, 8'hCC, 1'b0);  tick("valid_hold");
      drive(OP_ADD, 1'b1, 1'b1, 1'b0, OP_ADD, 8'h12, 8'h34, 1'b1);  tick("valid_hold2");
      v_in = 1'b1;
      tick("valid_load");
      v_in = 1'b0;
      drive(OP_NOT, 1'b1, 1'b0, 1'b0, OP_NOT, 8'h0F, 8'h00, 1'b0);  tick("valid_drop");
      v_in = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/top_alu.md
Name: top_alu

Overview:
- Registered WIDTH-bit ALU slice with carry/borrow chaining; default WIDTH=1 gives a single-bit slice.
- Performs 8 operations selected by a 3-bit opcode: logic, add, subtract and shift.
- Results and carry/borrow are registered on clk.
- Used as a standalone slice, or cascaded bit-serially by feeding CB_out back to CB_in.

Parameters:
- WIDTH, 1, data width of In1, In2 and Result (legal: >=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- CB_in  input  1  carry-in (ADD), borrow-in (SUB), shift-in bit (SHL/SHR); ignored by logic ops.
- code_op  input  3  operation select.
- Result  output  WIDTH  registered result.
- CB_out  output  1  registered carry-out / borrow-out / shifted-out bit.

Behaviour:
- One clock, synchronous active-low reset (rst_n sampled on rising clk edge); no asynchronous paths.
- Reset: Result=0, CB_out=0. Reset has priority over any operation in the same cycle.
- Reset mid-stream discards the in-flight result.
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Outputs hold between edges; no combinational input-to-output path.
- A new operation is accepted every cycle; no handshake.
- Opcode map:
  - 000 AND: Result=In1&In2, CB_out=0.
  - 001 OR: Result=In1|In2, CB_out=0.
  - 010 XOR: Result=In1^In2, CB_out=0.
  - 011 NOT: Result=~In1, CB_out=0 (In2 and CB_in ignored).
  - 100 ADD: {CB_out,Result}=In1+In2+CB_in, computed WIDTH+1 bits wide; CB_out is the carry.
  - 101 SUB: Result=(In1-In2-CB_in) mod 2^WIDTH; CB_out=1 iff In1 < In2+CB_in (unsigned borrow).
  - 110 SHL: Result={In1[WIDTH-2:0],CB_in}, CB_out=In1[WIDTH-1]. For WIDTH=1: Result=CB_in, CB_out=In1.
  - 111 SHR: Result={CB_in,In1[WIDTH-1:1]}, CB_out=In1[0]. For WIDTH=1: Result=CB_in, CB_out=In1.
- Wrap-around: ADD of all-ones+all-ones+1 gives Result=all-ones, CB_out=1. SUB of 0-0-1 gives Result=all-ones, CB_out=1.
- Inputs that are X/unknown are not supported. All opcodes are defined; no illegal-opcode state.

Optional Feature:
- Macro TOP_ALU_VALID_EN.
- Defined:
  - Adds input in_valid (1 bit) and output out_valid (1 bit, reset 0).
  - Result/CB_out load only when in_valid=1 at the edge, otherwise they hold.
  - out_valid is in_valid registered, so it is 1 exactly one cycle after an accepted op.
- Undefined: no extra ports; outputs load every cycle.

Decomposition:
- Package top_alu_pkg: opcode localparams OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NOT=3'b011, OP_ADD=3'b100, OP_SUB=3'b101, OP_SHL=3'b110, OP_SHR=3'b111.
- One sub-module, alu_bit_slice: a 1-bit full adder/subtractor (a, b, cb_in, sub -> sum, cb_out).
- top_alu instantiates WIDTH alu_bit_slice instances as a ripple chain for ADD/SUB. Logic, shift, opcode mux and output register live in top_alu.

Test Plan:
- Reset: hold rst_n=0 with In1=1, In2=1, code_op=100 -> Result=0, CB_out=0 after the edge. Release rst_n -> Result=1, CB_out=1 one cycle later.
- Exhaustive WIDTH=1 sweep, all 64 combos of {code_op,In1,In2,CB_in} -> each output matches the opcode map one cycle later. Examples:
  - ADD 1,1,1 -> R=1, CB=1.
  - SUB 0,1,0 -> R=1, CB=1.
  - SUB 1,0,1 -> R=0, CB=0.
  - XOR 1,1,x -> R=0, CB=0.
- WIDTH=8: ADD 0xFF+0x01+0 -> R=0x00, CB=1. SUB 0x10-0x01-1 -> R=0x0E, CB=0.
- WIDTH=8: SHL In1=0x81, CB_in=0 -> R=0x02, CB=1. SHR In1=0x81, CB_in=1 -> R=0xC0, CB=1.
- Back-to-back: change the opcode every cycle (AND, OR, NOT, ADD) -> each result appears exactly one cycle after its inputs, with no bubbles.
- TOP_ALU_VALID_EN: in_valid=0 with new operands -> outputs and out_valid=0 hold. in_valid=1 -> outputs update and out_valid=1 for one cycle.
